// File: rtl/ts_pkg.sv
// Shared constants, scan FSM states and the buffered beat payload for the
// time-surface read-side scanner.
package ts_pkg;

  localparam int unsigned GRID_SIZE    = 16;
  localparam int unsigned ADDR_BITS    = 8;
  localparam int unsigned COORD_BITS   = $clog2(GRID_SIZE);
  localparam int unsigned TS_BITS      = 16;
  localparam int unsigned VALUE_BITS   = 8;
  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned CNT_BITS     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_BITS     = CNT_BITS + 1;
  localparam int unsigned CELL_COUNT   = GRID_SIZE * GRID_SIZE;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(CELL_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [VALUE_BITS-1:0] value;
    logic [ADDR_BITS-1:0]  addr;
  } cell_beat_t;

  // Number of reads currently travelling through the read-latency pipe.
  function automatic logic [CNT_BITS-1:0] pipe_count(input logic [READ_LATENCY-1:0] bits);
    logic [CNT_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      n = n + CNT_BITS'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ts_scan_fifo.sv
// Small synchronous FIFO buffering returned cell reads; exposes its occupancy
// so the issuer can hand out read credits.
module ts_scan_fifo
  import ts_pkg::*;
#(
  parameter int unsigned WIDTH = VALUE_BITS + ADDR_BITS,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;
  logic [CNT_W-1:0]    count_next;

  always_comb begin
    do_push    = push && (count != CNT_W'(DEPTH));
    do_pop     = pop && valid;
    count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

  // Storage needs no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/time_surface_scanner.sv
// Scans every time-surface cell in raster order through the encoder read port
// and streams the decayed values out with coordinates and an end-of-frame flag.
module time_surface_scanner
  import ts_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TS_BITS-1:0]    t_now_in,
  output logic                  busy,
  output logic                  done,
  output logic [TS_BITS-1:0]    t_snap,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [VALUE_BITS-1:0] rd_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VALUE_BITS-1:0] out_value,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic                  out_last
);

  scan_state_t              state;
  scan_state_t              state_next;
  logic                     rd_en_next;
  logic [ADDR_BITS-1:0]     rd_addr_next;
  logic                     busy_next;
  logic                     done_next;
  logic [TS_BITS-1:0]       t_snap_next;

  logic [READ_LATENCY-1:0]  vpipe;
  logic [READ_LATENCY-1:0]  vpipe_next;
  logic [ADDR_BITS-1:0]     pipe_addr [READ_LATENCY];

  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [CNT_BITS-1:0]      occupancy;
  logic [SUM_BITS-1:0]      occ_next;
  logic [SUM_BITS-1:0]      inflight_next;

  cell_beat_t               push_beat;
  cell_beat_t               head_beat;

  // rd_en is registered, so credit is judged on next-cycle occupancy + inflight.
  always_comb begin
    state_next    = state;
    rd_addr_next  = rd_addr;
    t_snap_next   = t_snap;
    done_next     = 1'b0;
    issue         = rd_en;
    push          = vpipe[READ_LATENCY-1];
    pop           = out_valid && out_ready;
    vpipe_next    = (vpipe << 1) | READ_LATENCY'(issue);
    inflight_next = SUM_BITS'(pipe_count(vpipe_next));
    occ_next      = SUM_BITS'(occupancy) + SUM_BITS'(push) - SUM_BITS'(pop);

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = ISSUE;
          rd_addr_next = '0;
          t_snap_next  = t_now_in;
        end
      end
      ISSUE: begin
        if (issue) begin
          rd_addr_next = rd_addr + ADDR_BITS'(1);
          if (rd_addr == LAST_ADDR) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last && (vpipe == '0)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    rd_en_next = (state_next == ISSUE) &&
                 ((occ_next + inflight_next) < SUM_BITS'(FIFO_DEPTH));
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      t_snap  <= '0;
      vpipe   <= '0;
    end else begin
      state   <= state_next;
      rd_en   <= rd_en_next;
      rd_addr <= rd_addr_next;
      busy    <= busy_next;
      done    <= done_next;
      t_snap  <= t_snap_next;
      vpipe   <= vpipe_next;
    end
  end

  // Address travels alongside its valid bit; qualified by vpipe, so no reset.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= rd_addr;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign push_beat.value = rd_value;
  assign push_beat.addr  = pipe_addr[READ_LATENCY-1];

  ts_scan_fifo #(
    .WIDTH ($bits(cell_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head_beat),
    .valid     (out_valid),
    .count     (occupancy)
  );

  assign out_value = head_beat.value;
  assign out_x     = COORD_BITS'(head_beat.addr % ADDR_BITS'(GRID_SIZE));
  assign out_y     = COORD_BITS'(head_beat.addr / ADDR_BITS'(GRID_SIZE));
  assign out_last  = out_valid && (head_beat.addr == LAST_ADDR);

endmodule
